// File: rtl/width_pack_pkg.sv
// Shared types and widths for the byte-pair packing arbiter.
package width_pack_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    HOLD  = 2'd3
  } pack_state_t;

endpackage

// File: rtl/width_pack_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int k);
    return IDX_W'((int'(p) + k) % NUM_REQ);
  endfunction

  // Walk from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[wrap_idx(ptr, k)]) gnt_idx = wrap_idx(ptr, k);
    end
    gnt_onehot = any ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/width_pack_arbiter.sv
// Round-robin arbiter feeding one 8->16 byte-pair packer; grant held for a whole pair.
// Optional partial-pair flush on timeout when PACK_TIMEOUT_EN is defined.
module width_pack_arbiter
  import width_pack_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 15,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      valid_out,
  output logic [WORD_W-1:0]         data_out,
  output logic [IDX_W-1:0]          src_id,
  output logic                      partial,
  input  logic                      out_ready
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("width_pack_arbiter: unsupported NUM_REQ/TIMEOUT");
  end

  pack_state_t         state_q, state_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic                valid_q, valid_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    src_q, src_d;

`ifdef PACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                partial_q, partial_d;
`endif

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [BYTE_W-1:0]   g_byte;
  logic                accept;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req        (req_valid),
    .ptr        (rr_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    g_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) g_byte = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  // req_ready_q is one-hot on the locked grant whenever it is non-zero.
  assign accept = |(req_valid & req_ready_q);

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    hi_d        = hi_q;
    valid_d     = valid_q;
    data_d      = data_q;
    src_d       = src_q;
`ifdef PACK_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    partial_d   = partial_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_d = '0;
        if (pick_any) begin
          grant_d     = pick_idx;
          req_ready_d = pick_onehot;
          state_d     = BYTE0;
        end
      end
      BYTE0: begin
        if (accept) begin
          hi_d    = g_byte;
          state_d = BYTE1;
`ifdef PACK_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      BYTE1: begin
        if (accept) begin
          data_d      = {hi_q, g_byte};
          src_d       = grant_q;
          valid_d     = 1'b1;
          req_ready_d = '0;
          state_d     = HOLD;
`ifdef PACK_TIMEOUT_EN
          partial_d   = 1'b0;
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT)) begin
          data_d      = {hi_q, 8'h00};
          src_d       = grant_q;
          partial_d   = 1'b1;
          valid_d     = 1'b1;
          req_ready_d = '0;
          state_d     = HOLD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          // Drop ready one cycle early so a byte landing on the flush cycle stays with its requester.
          if ((tmo_cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) req_ready_d = '0;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          rr_d    = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= '0;
      grant_q     <= '0;
      rr_q        <= IDX_W'(NUM_REQ - 1);
      valid_q     <= 1'b0;
      data_q      <= '0;
      src_q       <= '0;
`ifdef PACK_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      partial_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      src_q       <= src_d;
`ifdef PACK_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      partial_q   <= partial_d;
`endif
    end
  end

  // The held byte is only consumed after being rewritten in BYTE0, so it needs no reset.
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
  end

  assign req_ready = req_ready_q;
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign src_id    = src_q;
`ifdef PACK_TIMEOUT_EN
  assign partial   = partial_q;
`else
  assign partial   = 1'b0;
`endif

endmodule
